// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner scheduler for the shared 8:1 mux: drives the mux select and a
// one-hot grant, rotating ownership on done, withdrawal, disable or hold expiry.
module mux8_rr_scheduler #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       valid
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, stateNext;
  logic [2:0] ptr, ptrNext;
  logic [7:0] cnt, cntNext;
  logic [2:0] selNext;
  logic [7:0] grantNext;
  logic       validNext;
  logic [2:0] scanBase;
  logic [3:0] arbResult;
  logic       found;
  logic [2:0] pick;
  logic       relCond;

  // Returns {found, index} of the first set request at or after base, wrapping 7->0.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While granting, the scan starts just past the current owner, which is where
  // the pointer lands on release; the owner itself is therefore checked last.
  assign scanBase  = (state == IDLE) ? ptr : (sel + 3'd1);
  assign arbResult = arbitrate(req, scanBase);
  assign found     = arbResult[3];
  assign pick      = arbResult[2:0];
  assign relCond   = done || (cnt == 8'd0) || !req[sel] || !en;

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    selNext   = sel;
    grantNext = grant;
    validNext = valid;
    case (state)
      IDLE: begin
        grantNext = 8'h00;
        validNext = 1'b0;
        if (en && found) begin
          stateNext = GRANT;
          selNext   = pick;
          grantNext = 8'h01 << pick;
          validNext = 1'b1;
          cntNext   = HOLD_INIT;
        end
      end
      GRANT: begin
        if (relCond) begin
          ptrNext = sel + 3'd1;
          if (en && found) begin
            // Back-to-back handover, including a lone requester regranting itself.
            selNext   = pick;
            grantNext = 8'h01 << pick;
            validNext = 1'b1;
            cntNext   = HOLD_INIT;
          end else begin
            stateNext = IDLE;
            grantNext = 8'h00;
            validNext = 1'b0;
          end
        end else begin
          cntNext = cnt - 8'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = 8'h00;
        validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= 8'd0;
      sel   <= 3'd0;
      grant <= 8'h00;
      valid <= 1'b0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      cnt   <= cntNext;
      sel   <= selNext;
      grant <= grantNext;
      valid <= validNext;
    end
  end

endmodule
